// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, scheduler FSM encodings and the baud
// constants that both the transmitter and the scheduler are built against.
package uart_pkg;

  typedef logic [7:0] byte_t;

  // Arbiter: no owner / one requester owns the FIFO input until release.
  typedef enum logic {
    A_IDLE,
    A_OWN
  } arb_state_t;

  // Sender: transmitter idle / a byte is being framed on the line.
  typedef enum logic {
    S_IDLE,
    S_SEND
  } snd_state_t;

  // System clock and line rate; UI_COUNTER is clocks per bit, rounded.
  localparam int unsigned CLK_FREQ_HZ  = 120_000_000;
  localparam int unsigned BAUD_RATE    = 115_200;
  localparam int unsigned UI_COUNTER   = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned UI_COUNTER_W = $clog2(UI_COUNTER);

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through read data. Full and empty
// are decoded from a registered occupancy count; pointers wrap naturally
// because DEPTH is a power of two.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage write port.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by
  // level_q, so stale entries are never observable and the RAM stays flop-free.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: round-robin arbitration between byte producers at
// message granularity, a small TX FIFO, and the valid/complete handshake to
// the transmitter with the byte held stable for its whole frame.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 64
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [8*NUM_REQ-1:0]          req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_complete,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  // Arbiter state
  arb_state_t           arb_q;
  logic [OWN_W-1:0]     owner_q;
  logic [OWN_W-1:0]     rr_ptr_q;     // first index searched on the next grant
  logic [BURST_W-1:0]   burst_q;

  // Sender state
  snd_state_t           snd_q;
  logic                 tx_valid_q;
  byte_t                tx_data_q;

  // FIFO interface
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  byte_t                fifo_rdata;
  byte_t                owner_data;

  // Combinational helpers
  logic                 grant_found;
  logic [OWN_W-1:0]     grant_idx;
  logic [OWN_W-1:0]     cand;
  logic [OWN_W-1:0]     next_rr;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 burst_hit;

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_data  = req_data[{owner_q, 3'b000} +: 8];
  assign next_rr     = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign burst_hit   = (MAX_BURST != 0) && (burst_q == BURST_W'(MAX_BURST - 1));
  assign fifo_push   = (arb_q == A_OWN) && owner_valid && !fifo_full;
  assign fifo_pop    = !fifo_empty &&
                       ((snd_q == S_IDLE) || ((snd_q == S_SEND) && tx_complete));

  // Round-robin search: first valid requester at or after rr_ptr_q.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave a value held and infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = OWN_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Only the owner sees ready, and only while the registered full flag is low.
  always_comb begin
    req_ready = '0;
    if (arb_q == A_OWN) begin
      req_ready[owner_q] = !fifo_full;
    end
  end

  // Arbiter FSM: grant on any request, release on last byte or burst limit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      arb_q    <= A_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
    end else begin
      case (arb_q)
        A_IDLE: begin
          if (grant_found) begin
            arb_q   <= A_OWN;
            owner_q <= grant_idx;
            burst_q <= '0;
          end
        end
        A_OWN: begin
          if (fifo_push) begin
            if (owner_last || burst_hit) begin
              arb_q    <= A_IDLE;
              rr_ptr_q <= next_rr;
            end else if (MAX_BURST != 0) begin
              burst_q <= burst_q + 1'b1;
            end
          end
        end
        default: arb_q <= A_IDLE;
      endcase
    end
  end

  // Sender FSM: load a byte when idle, chain the next one on tx_complete.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      snd_q      <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (snd_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            tx_data_q  <= fifo_rdata;
            tx_valid_q <= 1'b1;
            snd_q      <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_complete) begin
            if (!fifo_empty) begin
              tx_data_q <= fifo_rdata;
            end else begin
              tx_valid_q <= 1'b0;
              snd_q      <= S_IDLE;
            end
          end
        end
        default: snd_q <= S_IDLE;
      endcase
    end
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .push_i  (fifo_push),
    .wdata_i (owner_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = (arb_q == A_OWN) || !fifo_empty || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a random
// phase, all compared each cycle against a queue-based behavioural model.
module tb_uart_tx_sched;

  localparam int NUM_REQ    = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_complete = 1'b0;
  logic [LW-1:0]        fifo_level;
  logic                 busy;

  always #5 clock = ~clock;

  uart_tx_sched #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_complete (tx_complete),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester sources: {last, data} entries, popped when the model accepts.
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  bit [1:0]   src_en     = 2'b11;
  bit         rand_valid = 1'b0;

  function automatic int src_size(input int i);
    return (i == 0) ? src0.size() : src1.size();
  endfunction

  function automatic logic [8:0] src_head(input int i);
    return (i == 0) ? src0[0] : src1[0];
  endfunction

  task automatic src_push(input int i, input logic [8:0] e);
    if (i == 0) src0.push_back(e); else src1.push_back(e);
  endtask

  task automatic src_pop(input int i);
    if (i == 0) void'(src0.pop_front()); else void'(src1.pop_front());
  endtask

  // Behavioural model: owner index (-1 = none), next search start, bytes in
  // the current ownership, buffered bytes and the byte on the line.
  int         m_owner;
  int         m_rr;
  int         m_burst;
  logic [7:0] m_fifo[$];
  bit         m_txv;
  logic [7:0] m_txd;

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_burst = 0;
    m_fifo.delete();
    m_txv   = 1'b0;
    m_txd   = 8'h00;
  endtask

  function automatic bit model_idle();
    return (m_owner < 0) && (m_fifo.size() == 0) && !m_txv &&
           (src0.size() == 0) && (src1.size() == 0);
  endfunction

  task automatic model_step(input logic [1:0] v, input logic [15:0] d, input logic [1:0] l,
                            input logic txc, output logic [1:0] acc);
    bit full;
    int o;
    full = (m_fifo.size() >= FIFO_DEPTH);
    o    = m_owner;
    acc  = '0;
    if (o >= 0 && v[o] && !full) acc[o] = 1'b1;
    if (!m_txv) begin
      if (m_fifo.size() > 0) begin
        m_txd = m_fifo.pop_front();
        m_txv = 1'b1;
      end
    end else if (txc) begin
      if (m_fifo.size() > 0) m_txd = m_fifo.pop_front();
      else m_txv = 1'b0;
    end
    if (o >= 0) begin
      if (acc[o]) begin
        m_fifo.push_back(d[8*o +: 8]);
        m_burst++;
        if (l[o] || (MAX_BURST != 0 && m_burst == MAX_BURST)) begin
          m_owner = -1;
          m_rr    = (o + 1) % NUM_REQ;
        end
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (m_rr + k) % NUM_REQ;
        if (v[j]) begin
          m_owner = j;
          m_burst = 0;
          break;
        end
      end
    end
  endtask

  // Transmitter emulation and logs
  bit         hold       = 1'b0;
  bit         pulse_once = 1'b0;
  bit         stray      = 1'b0;
  int         frame_cnt  = 2;
  logic [7:0] sent_log[$];
  int         grant_log[$];
  int         cyc = 0;
  int         acc0_cyc = 0;
  int         first_txv_cyc = -1;

  // One clock: compare outputs against the model, drive new inputs, advance.
  task automatic step();
    logic [1:0]  v;
    logic [1:0]  l;
    logic [1:0]  acc;
    logic [1:0]  exp_rdy;
    logic [15:0] d;
    logic [8:0]  h;
    logic        txc;
    @(negedge clock);
    cyc++;
    exp_rdy = '0;
    if (m_owner >= 0 && m_fifo.size() < FIFO_DEPTH) exp_rdy[m_owner] = 1'b1;
    check("req_ready",  32'(req_ready),  32'(exp_rdy));
    check("tx_valid",   32'(tx_valid),   32'(m_txv));
    check("tx_data",    32'(tx_data),    32'(m_txd));
    check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    check("busy",       32'(busy),       32'((m_owner >= 0) || (m_fifo.size() > 0) || m_txv));
    if (tx_valid && first_txv_cyc < 0) first_txv_cyc = cyc;

    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = src_en[i] && (src_size(i) > 0) && (!rand_valid || $urandom_range(3) != 0);
      if (src_size(i) > 0) begin
        h = src_head(i);
        d[8*i +: 8] = h[7:0];
        l[i] = h[8];
      end else begin
        d[8*i +: 8] = 8'($urandom);
        l[i] = 1'($urandom);
      end
    end

    if (pulse_once) begin
      txc = 1'b1;
      pulse_once = 1'b0;
    end else if (hold) begin
      txc = 1'b0;
    end else if (m_txv) begin
      if (frame_cnt == 0) begin
        txc = 1'b1;
        frame_cnt = $urandom_range(6, 1);
      end else begin
        frame_cnt--;
        txc = 1'b0;
      end
    end else begin
      txc = stray ? 1'($urandom_range(1)) : 1'b0;
    end

    req_valid   = v;
    req_data    = d;
    req_last    = l;
    tx_complete = txc;

    for (int i = 0; i < NUM_REQ; i++)
      if (v[i] && req_ready[i]) grant_log.push_back(i);
    if (txc && tx_valid) sent_log.push_back(tx_data);

    model_step(v, d, l, txc, acc);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        src_pop(i);
        if (i == 0) acc0_cyc = cyc;
      end
    end
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n = 0;
    while (!model_idle() && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(n < max_cyc), 32'd1);
    repeat (2) step();
  endtask

  task automatic apply_reset();
    resetn      = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    tx_complete = 1'b0;
    src0.delete();
    src1.delete();
    model_reset();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic check_seq(input string tag, input logic [7:0] exp[$]);
    check({tag, "_len"}, 32'(sent_log.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < sent_log.size(); k++)
      check(tag, 32'(sent_log[k]), 32'(exp[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp[$];
    int total;
    int n;
    int len;
    int sent_before;

    // Reset state
    apply_reset();
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);

    // Single byte, latency from acceptance to tx_valid
    src_push(0, {1'b1, 8'h41});
    first_txv_cyc = -1;
    sent_log.delete();
    run_until_idle(200, "single_done");
    check("single_latency", 32'(first_txv_cyc - acc0_cyc), 32'd2);
    exp = '{8'h41};
    check_seq("single_byte", exp);
    check("single_tx_valid_end", 32'(tx_valid), 32'd0);
    check("single_busy_end",     32'(busy),     32'd0);

    // Non-interleave from reset
    apply_reset();
    sent_log.delete();
    src_push(0, {1'b0, "A"}); src_push(0, {1'b0, "B"}); src_push(0, {1'b1, "C"});
    src_push(1, {1'b0, "x"}); src_push(1, {1'b1, "y"});
    run_until_idle(300, "nonint_done");
    exp = '{"A", "B", "C", "x", "y"};
    check_seq("nonint_order", exp);

    // Round-robin on single-byte messages
    sent_log.delete();
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      src_push(0, {1'b1, 8'(8'h30 + k)});
      src_push(1, {1'b1, 8'(8'h60 + k)});
    end
    run_until_idle(400, "rr_done");
    check("rr_grants_len", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size(); k++)
      check("rr_grant", 32'(grant_log[k]), 32'(k % 2));

    // MAX_BURST release: req1 waits behind req0's stream
    sent_log.delete();
    grant_log.delete();
    src_en = 2'b01;
    for (int k = 0; k < 6; k++) src_push(0, {(k == 5), 8'(8'h10 + k)});
    src_push(1, {1'b0, "P"}); src_push(1, {1'b1, "Q"});
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin step(); n++; end
    check("burst_first_accept", 32'(n < 20), 32'd1);
    src_en = 2'b11;
    run_until_idle(400, "burst_done");
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, "P", "Q", 8'h14, 8'h15};
    check_seq("burst_order", exp);

    // Full FIFO with tx_complete withheld
    sent_log.delete();
    grant_log.delete();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) src_push(0, {(k == 9), 8'(8'hA0 + k)});
    repeat (30) step();
    check("full_accepted",  32'(grant_log.size()), 32'd9);
    check("full_level",     32'(fifo_level),       32'd8);
    check("full_req_ready", 32'(req_ready),        32'd0);
    check("full_tx_valid",  32'(tx_valid),         32'd1);
    pulse_once = 1'b1;
    repeat (6) step();
    check("full_accepted_after", 32'(grant_log.size()), 32'd10);
    check("full_level_after",    32'(fifo_level),       32'd8);
    hold = 1'b0;
    run_until_idle(400, "full_drain");
    exp.delete();
    for (int k = 0; k < 10; k++) exp.push_back(8'(8'hA0 + k));
    check_seq("full_order", exp);

    // Random messages, random valid gaps, frame lengths and stray completes
    sent_log.delete();
    rand_valid = 1'b1;
    stray = 1'b1;
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int m = 0; m < 6; m++) begin
        len = $urandom_range(6, 1);
        for (int b = 0; b < len; b++) src_push(i, {(b == len - 1), 8'($urandom)});
        total += len;
      end
    end
    run_until_idle(4000, "rand_done");
    check("rand_count", 32'(sent_log.size()), 32'(total));
    rand_valid = 1'b0;
    stray = 1'b0;

    // Asynchronous reset mid-frame with 3 bytes buffered
    hold = 1'b1;
    for (int k = 0; k < 5; k++) src_push(0, {(k == 4), 8'(8'hC0 + k)});
    n = 0;
    while (fifo_level !== LW'(3) && n < 40) begin step(); n++; end
    check("arst_setup", 32'(n < 40), 32'd1);
    check("arst_pre_tx_valid", 32'(tx_valid), 32'd1);
    #2;
    resetn = 1'b0;
    req_valid = '0;
    #1;
    check("arst_tx_valid",   32'(tx_valid),   32'd0);
    check("arst_req_ready",  32'(req_ready),  32'd0);
    check("arst_fifo_level", 32'(fifo_level), 32'd0);
    check("arst_busy",       32'(busy),       32'd0);
    model_reset();
    src0.delete();
    src1.delete();
    sent_before = sent_log.size();
    tx_complete = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    hold = 1'b0;
    stray = 1'b1;
    repeat (10) step();
    check("arst_stray_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_stray_busy",     32'(busy),     32'd0);
    check("arst_stray_sent",     32'(sent_log.size()), 32'(sent_before));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler sitting between several on-chip byte producers (CPU register port, debug monitor, trace unit) and the single UART transmitter. It arbitrates round-robin between requesters at message granularity so multi-byte strings are never interleaved, buffers accepted bytes in a small FIFO, and sequences the transmitter's valid/complete handshake, holding each byte stable for its whole frame.

## Interface
- NUM_REQ, 2: number of requesters (1..4)
- FIFO_DEPTH, 8: TX buffer entries (power of two, ≥2)
- MAX_BURST, 64: bytes an owner may send before forced release (0 = unlimited)
- clock  in  1  system clock (120 MHz)
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i presents a byte
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last of requester i's message
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle when valid&ready
- tx_valid  out  1  to transmitter: byte in tx_data to be sent
- tx_data  out  8  to transmitter: byte, stable while tx_valid high
- tx_complete  in  1  from transmitter: one-cycle pulse at start of stop bit
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes buffered, excluding the byte in flight
- busy  out  1  owner held, FIFO non-empty, or tx_valid high

## Operation
- Reset values: req_ready=0, tx_valid=0, tx_data=8'h00, fifo_level=0, busy=0; no owner; round-robin pointer=0; sender state S_IDLE.
- Arbiter states A_IDLE, A_OWN. In A_IDLE, any req_valid → owner = first valid index searching upward from (last_owner+1) mod NUM_REQ, register into A_OWN; burst count cleared.
- In A_OWN: req_ready[owner] = !fifo_full (registered full flag); all other req_ready = 0. Push on req_valid&req_ready.
- Release to A_IDLE on the push of a byte with req_last=1, or on the push that makes burst count reach MAX_BURST (MAX_BURST≠0). last_owner updated on release.
- Owner dropping req_valid without req_last keeps ownership (no timeout).
- Sender states S_IDLE, S_SEND. S_IDLE with FIFO non-empty: pop into tx_data, tx_valid←1, → S_SEND.
- S_SEND: hold tx_data/tx_valid. On tx_complete: if FIFO non-empty, pop next byte into tx_data, stay S_SEND with tx_valid high (transmitter samples it once its stop bit ends); else tx_valid←0, → S_IDLE.
- tx_complete in S_IDLE is ignored.
- Push and pop in the same cycle: both occur, level unchanged. Push is gated on registered full only, so a full FIFO rejects even in a popping cycle.
- Pointers wrap modulo FIFO_DEPTH; full/empty from level count.

## Timing
- Idle path: byte accepted at edge N → FIFO non-empty after N → tx_valid high after edge N+1.
- Back-to-back: next tx_data presented in the cycle after tx_complete; no idle frames between buffered bytes.
- New owner grant: one cycle from req_valid seen in A_IDLE to req_ready high.
- Reset is asynchronous assert, synchronous deassert (deassertion synchronised externally); mid-frame reset drops tx_valid immediately and discards the FIFO. Transmitter is reset by the same source.

## Structure
- Shared uart_pkg: byte_t (logic [7:0]), arb_state_t, snd_state_t enums, and the UI_COUNTER baud constants so transmitter and scheduler agree.
- One sub-module: uart_fifo (synchronous FIFO, push/pop/full/empty/level, parameterised depth and width); arbiter and sender FSMs live in uart_tx_sched.

## Test plan
- Single byte: req0 sends 8'h41 last=1 → tx_valid high 2 cycles later with tx_data=8'h41, held until tx_complete, then tx_valid low, busy low.
- Non-interleave: req0 "ABC" (last on C) and req1 "xy" valid simultaneously from reset → transmitted order A,B,C,x,y; req1 ready stays 0 until C pushed.
- Round-robin: both requesters send repeated 1-byte messages → grants alternate 0,1,0,1.
- Full FIFO: req0 pushes 10 bytes while tx_complete withheld → 1 in flight + 8 buffered, req_ready low, fifo_level=8; one tx_complete → one more accepted.
- MAX_BURST=4: req0 streams 6 bytes without last, req1 waiting → after 4 bytes req1's message is sent, then req0's remaining 2.
- Async reset mid-frame: resetn low during S_SEND with 3 bytes buffered → tx_valid, req_ready, fifo_level, busy all 0 immediately; stray tx_complete afterwards produces no output.
